// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage: widths, ALU opcodes, operand selects.
package ex_operand_stage_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int ALU_SEL_SIZE   = 4;

   localparam logic [ALU_SEL_SIZE-1:0] ALU_NOP = 4'd0;
   localparam logic [ALU_SEL_SIZE-1:0] ALU_ADD = 4'd1;
   localparam logic [ALU_SEL_SIZE-1:0] ALU_SUB = 4'd2;

   localparam logic [1:0] A_SEL_RS1     = 2'b00;
   localparam logic [1:0] A_SEL_PC      = 2'b01;
   localparam logic [1:0] A_SEL_ZERO    = 2'b10;
   localparam logic [1:0] A_SEL_RS1_ALT = 2'b11;

   localparam logic B_SEL_RS2 = 1'b0;
   localparam logic B_SEL_IMM = 1'b1;

   // Operand A consumes rs1 for both the primary and the alternate rs1 encodings.
   function automatic logic a_uses_rs1(input logic [1:0] a_sel);
      return (a_sel == A_SEL_RS1) || (a_sel == A_SEL_RS1_ALT);
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand bypass mux: EX/MEM result first, then MEM/WB, else regfile data.
module ex_operand_stage_fwd_mux #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic [DATA_WIDTH-1:0] rf_data,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_rd_we,
   input  logic                  mem_is_load,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_rd_we,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [DATA_WIDTH-1:0] fwd_data
);

   // A load in MEM has no data yet, so it is never a bypass source; x0 is never bypassed.
   always_comb begin
      fwd_data = rf_data;
      if (src == '0)
         fwd_data = rf_data;
      else if (mem_rd_we && (mem_rd == src) && !mem_is_load)
         fwd_data = mem_data;
      else if (wb_rd_we && (wb_rd == src))
         fwd_data = wb_data;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register: holds one decoded instruction, bypasses its sources,
// stalls on load-use hazards and presents ALU operands plus writeback metadata.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_pc,
   input  logic [REG_ADDR_W-1:0]   in_rs1_addr,
   input  logic [REG_ADDR_W-1:0]   in_rs2_addr,
   input  logic [DATA_WIDTH-1:0]   in_rs1_data,
   input  logic [DATA_WIDTH-1:0]   in_rs2_data,
   input  logic [DATA_WIDTH-1:0]   in_imm,
   input  logic [1:0]              in_a_sel,
   input  logic                    in_b_sel,
   input  logic [ALU_SEL_SIZE-1:0] in_alu_sel,
   input  logic [REG_ADDR_W-1:0]   in_rd,
   input  logic                    in_rd_we,
   input  logic                    in_is_load,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   alu_a,
   output logic [DATA_WIDTH-1:0]   alu_b,
   output logic [ALU_SEL_SIZE-1:0] alu_sel,
   output logic [DATA_WIDTH-1:0]   out_pc,
   output logic [DATA_WIDTH-1:0]   out_store_data,
   output logic [REG_ADDR_W-1:0]   out_rd,
   output logic                    out_rd_we,
   output logic                    out_is_load,
   input  logic [REG_ADDR_W-1:0]   mem_rd,
   input  logic                    mem_rd_we,
   input  logic                    mem_is_load,
   input  logic [DATA_WIDTH-1:0]   mem_data,
   input  logic [REG_ADDR_W-1:0]   wb_rd,
   input  logic                    wb_rd_we,
   input  logic [DATA_WIDTH-1:0]   wb_data
);

   logic                    occupied;
   logic [DATA_WIDTH-1:0]   held_pc;
   logic [REG_ADDR_W-1:0]   held_rs1_addr;
   logic [REG_ADDR_W-1:0]   held_rs2_addr;
   logic [DATA_WIDTH-1:0]   held_rs1_data;
   logic [DATA_WIDTH-1:0]   held_rs2_data;
   logic [DATA_WIDTH-1:0]   held_imm;
   logic [1:0]              held_a_sel;
   logic                    held_b_sel;
   logic [ALU_SEL_SIZE-1:0] held_alu_sel;
   logic [REG_ADDR_W-1:0]   held_rd;
   logic                    held_rd_we;
   logic                    held_is_load;

   logic [DATA_WIDTH-1:0]   fwd_rs1;
   logic [DATA_WIDTH-1:0]   fwd_rs2;
   logic                    hazard;
   logic                    fire_in;
   logic                    fire_out;

   // Handshake: a transfer happens on a rising edge where valid & ready are both high.
   // Valid never waits on ready; in_ready depends combinationally on out_ready, so a
   // held entry can leave and a new one enter on the same edge (no skid buffer).
   assign fire_in  = in_valid & in_ready;
   assign fire_out = out_valid & out_ready;
   assign in_ready = !occupied | fire_out;

   // rs2 is checked regardless of b_sel: stores take imm on B but still need rs2 data.
   assign hazard = occupied & mem_rd_we & mem_is_load & (mem_rd != '0) &
                   ((a_uses_rs1(held_a_sel) & (mem_rd == held_rs1_addr)) |
                    (mem_rd == held_rs2_addr));

   assign out_valid = occupied & !hazard;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupied      <= 1'b0;
         held_pc       <= '0;
         held_rs1_addr <= '0;
         held_rs2_addr <= '0;
         held_rs1_data <= '0;
         held_rs2_data <= '0;
         held_imm      <= '0;
         held_a_sel    <= '0;
         held_b_sel    <= 1'b0;
         held_alu_sel  <= ALU_NOP;
         held_rd       <= '0;
         held_rd_we    <= 1'b0;
         held_is_load  <= 1'b0;
      end else if (flush) begin
         occupied <= 1'b0;
      end else if (fire_in) begin
         occupied      <= 1'b1;
         held_pc       <= in_pc;
         held_rs1_addr <= in_rs1_addr;
         held_rs2_addr <= in_rs2_addr;
         held_rs1_data <= in_rs1_data;
         held_rs2_data <= in_rs2_data;
         held_imm      <= in_imm;
         held_a_sel    <= in_a_sel;
         held_b_sel    <= in_b_sel;
         held_alu_sel  <= in_alu_sel;
         held_rd       <= in_rd;
         held_rd_we    <= in_rd_we;
         held_is_load  <= in_is_load;
      end else if (fire_out) begin
         occupied <= 1'b0;
      end
   end

   ex_operand_stage_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
      .src        (held_rs1_addr),
      .rf_data    (held_rs1_data),
      .mem_rd     (mem_rd),
      .mem_rd_we  (mem_rd_we),
      .mem_is_load(mem_is_load),
      .mem_data   (mem_data),
      .wb_rd      (wb_rd),
      .wb_rd_we   (wb_rd_we),
      .wb_data    (wb_data),
      .fwd_data   (fwd_rs1)
   );

   ex_operand_stage_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
      .src        (held_rs2_addr),
      .rf_data    (held_rs2_data),
      .mem_rd     (mem_rd),
      .mem_rd_we  (mem_rd_we),
      .mem_is_load(mem_is_load),
      .mem_data   (mem_data),
      .wb_rd      (wb_rd),
      .wb_rd_we   (wb_rd_we),
      .wb_data    (wb_data),
      .fwd_data   (fwd_rs2)
   );

   always_comb begin
      alu_a = fwd_rs1;
      case (held_a_sel)
         A_SEL_PC:   alu_a = held_pc;
         A_SEL_ZERO: alu_a = '0;
         default:    alu_a = fwd_rs1;
      endcase
   end

   assign alu_b          = (held_b_sel == B_SEL_IMM) ? held_imm : fwd_rs2;
   assign out_store_data = fwd_rs2;
   assign out_pc         = held_pc;
   assign out_rd         = held_rd;

   // An empty stage must look like a NOP that writes nothing back.
   assign alu_sel     = occupied ? held_alu_sel : ALU_NOP;
   assign out_rd_we   = occupied & held_rd_we;
   assign out_is_load = occupied & held_is_load;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures one decoded instruction per handshake.
- Selects operand A from rs1/PC/zero and operand B from rs2/immediate.
- Applies MEM/WB forwarding, detects load-use hazards, and presents alu_a/alu_b/alu_sel plus writeback metadata to the execute stage.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (32), operand/PC width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept
- in_pc  in  DATA_WIDTH  instruction PC
- in_rs1_addr, in_rs2_addr  in  REG_ADDR_W  source indices
- in_rs1_data, in_rs2_data  in  DATA_WIDTH  regfile read data
- in_imm  in  DATA_WIDTH  sign-extended immediate
- in_a_sel  in  2  00=rs1, 01=PC, 10=zero, 11=rs1
- in_b_sel  in  1  0=rs2, 1=imm
- in_alu_sel  in  `ALU_SEL_SIZE  ALU opcode
- in_rd  in  REG_ADDR_W  destination
- in_rd_we  in  1  destination write enable
- in_is_load  in  1  instruction is a load
- flush  in  1  kill held instruction (branch redirect)
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- alu_sel  out  `ALU_SEL_SIZE  ALU opcode
- out_pc  out  DATA_WIDTH  held PC
- out_store_data  out  DATA_WIDTH  forwarded rs2 value
- out_rd  out  REG_ADDR_W, out_rd_we  out  1, out_is_load  out  1  carried metadata
- mem_rd  in  REG_ADDR_W, mem_rd_we  in  1, mem_is_load  in  1, mem_data  in  DATA_WIDTH  EX/MEM forwarding source
- wb_rd  in  REG_ADDR_W, wb_rd_we  in  1, wb_data  in  DATA_WIDTH  MEM/WB forwarding source

Behaviour:
- Reset (async, rst_n=0):
  - occupied=0; all held fields 0.
  - Held alu_sel=`ALU_NOP; out_valid=0, out_rd_we=0, out_is_load=0.
  - in_ready=1 once reset deasserts.
- Single-entry register. fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- in_ready = !occupied | fire_out. This is a combinational path out_ready→in_ready; no skid buffer.
- Rising edge, priority order:
  1. flush: occupied←0, ignore fire_in that cycle.
  2. fire_in: load all fields, occupied←1.
  3. fire_out only: occupied←0.
  4. Otherwise: hold.
- Zero-bubble throughput: fire_in and fire_out in the same cycle reloads.
- While !occupied, alu_sel output is `ALU_NOP and out_rd_we=0, so the ALU yields 0 and nothing writes back.
- Forwarding is combinational on held fields and live mem_*/wb_* inputs, applied to rs1 and rs2 independently:
  - src==0 → held regfile data. x0 is never forwarded.
  - else mem_rd_we & mem_rd==src & !mem_is_load → mem_data. MEM has priority.
  - else wb_rd_we & wb_rd==src → wb_data.
  - else held regfile data.
- Operand selection:
  - alu_a = {fwd_rs1, held_pc, 0, fwd_rs1}[a_sel].
  - alu_b = b_sel ? held_imm : fwd_rs2.
  - out_store_data = fwd_rs2 always.
- Load-use hazard:
  - Condition: occupied & mem_rd_we & mem_is_load & mem_rd!=0 & mem_rd matches an operand actually used.
  - rs1 is used when a_sel∈{00,11}. rs2 is used when b_sel=0 or the held instruction is a store. Stores carry b_sel=1 (imm), so rs2 is always checked for stores; the conservative rule is to check rs2 unconditionally.
  - Effect: out_valid forced 0, in_ready=0, held state unchanged. Resolves automatically when the load leaves MEM.
- out_valid = occupied & !hazard.
- Flush during a hazard stall clears occupied; the hazard is then moot.
- Downstream backpressure (out_ready=0) holds all outputs stable. Forwarded values may still change as mem/wb sources change; this is intended.

Decomposition:
- Shared types.sv (existing):
  - A_SEL_RS1/A_SEL_PC/A_SEL_ZERO and B_SEL_RS2/B_SEL_IMM defines.
  - `ALU_NOP and `ALU_SEL_SIZE (reused).
  - REG_ADDR_W define.
- Sub-module fwd_mux: one instance per source operand. Inputs: src addr, regfile data, mem_*, wb_*. Output: forwarded data. Pure combinational.
- Hazard detection and handshake stay in the top module.

Test Plan:
1. Reset: assert rst_n=0 mid-transfer → out_valid=0, alu_sel=`ALU_NOP, out_rd_we=0 immediately (async); in_ready=1 after release.
2. Streaming: issue ADD rs1=x1(5), rs2=x2(7), b_sel=0 back-to-back with out_ready=1 → one out_valid per cycle, alu_a=5, alu_b=7; then out_ready=0 for 3 cycles → in_ready=0, outputs frozen.
3. Forwarding priority: held rs1=x3 (regfile 1), mem_rd=x3/we=1/data=0xAA, wb_rd=x3/data=0xBB → alu_a=0xAA; drop mem_rd_we → 0xBB; rs1=x0 with mem_rd=x0 → alu_a=0.
4. Load-use: held rs2=x4, b_sel=0, mem_rd=x4, mem_is_load=1 → out_valid=0, in_ready=0 for that cycle; next cycle mem_is_load=0, wb_rd=x4/data=0x1234 → out_valid=1, alu_b=0x1234.
5. Flush: flush=1 simultaneous with in_valid=1 → next cycle out_valid=0, new instruction dropped, alu_sel=`ALU_NOP.
6. Operand selects: a_sel=01, pc=0x100, b_sel=1, imm=0xFFFFFFFC → alu_a=0x100, alu_b=0xFFFFFFFC; a_sel=10 → alu_a=0.
